// File: rtl/reg_bank_sb_pkg.sv
// ---------------------------------------------------------------------------
// reg_bank_sb_pkg
// Shared constants for the scoreboarded register bank: default data and
// address widths, the index of the hard-wired zero register, and the width
// of the accepted-write counter.
// ---------------------------------------------------------------------------
package reg_bank_sb_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_ADDR_W = 5;
    localparam int ZERO_REG_IDX   = 0;
    localparam int WR_COUNT_W     = 16;

endpackage : reg_bank_sb_pkg

// File: rtl/reg_bank_sb_if.sv
// ---------------------------------------------------------------------------
// reg_bank_sb_if
// Bundles the read, write-back and issue signals of the register bank.
//   master : drives a1/a2 (read addresses), a3/wd/we (write-back),
//            iss_valid/iss_rd (issue); observes rd1/rd2, busy1/busy2,
//            iss_ready and wr_count.
//   slave  : the register bank side, directions reversed.
// ---------------------------------------------------------------------------
interface reg_bank_sb_if
    import reg_bank_sb_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W
) ();

    logic [ADDR_W-1:0]     a1;
    logic [ADDR_W-1:0]     a2;
    logic [DATA_W-1:0]     rd1;
    logic [DATA_W-1:0]     rd2;
    logic                  busy1;
    logic                  busy2;
    logic [ADDR_W-1:0]     a3;
    logic [DATA_W-1:0]     wd;
    logic                  we;
    logic                  iss_valid;
    logic [ADDR_W-1:0]     iss_rd;
    logic                  iss_ready;
    logic [WR_COUNT_W-1:0] wr_count;

    modport master (
        output a1, a2, a3, wd, we, iss_valid, iss_rd,
        input  rd1, rd2, busy1, busy2, iss_ready, wr_count
    );

    modport slave (
        input  a1, a2, a3, wd, we, iss_valid, iss_rd,
        output rd1, rd2, busy1, busy2, iss_ready, wr_count
    );

endinterface : reg_bank_sb_if

// File: rtl/reg_bank_sb_score.sv
// ---------------------------------------------------------------------------
// reg_bank_sb_score
// Busy-bit scoreboard: one reservation bit per register. An accepted issue
// sets the destination bit, a write-back clears its target bit, and when
// both hit the same register in one cycle the new reservation wins.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_a1, i_a2        read addresses whose busy bits are reported
//   i_a3, i_we        write-back address and enable
//   i_issValid        issue request
//   i_issRd           issue destination register
//   o_busy1, o_busy2  busy bits for i_a1 / i_a2
//   o_issReady        issue can be accepted this cycle
// ---------------------------------------------------------------------------
module reg_bank_sb_score
    import reg_bank_sb_pkg::*;
#(
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] i_a1,
    input  logic [ADDR_W-1:0] i_a2,
    input  logic [ADDR_W-1:0] i_a3,
    input  logic              i_we,
    input  logic              i_issValid,
    input  logic [ADDR_W-1:0] i_issRd,
    output logic              o_busy1,
    output logic              o_busy2,
    output logic              o_issReady
);

    localparam int                DEPTH     = 1 << ADDR_W;
    localparam bit                L_ZERO_EN = (ZERO_REG != 0);
    localparam bit                L_BYPASS  = (BYPASS != 0);
    localparam logic [ADDR_W-1:0] L_ZERO_A  = ADDR_W'(ZERO_REG_IDX);

    logic [DEPTH-1:0] r_busy;
    logic [DEPTH-1:0] w_busyNext;
    logic             w_issRdZero;
    logic             w_issAccept;

    // The zero register can never be reserved, so issues to it are always
    // ready yet never set a bit. A write-back landing on the requested
    // destination this cycle frees it in time for the new reservation.
    always_comb begin
        w_issRdZero = L_ZERO_EN && (i_issRd == L_ZERO_A);
        o_issReady  = !r_busy[i_issRd] || (i_we && (i_a3 == i_issRd)) || w_issRdZero;
        w_issAccept = i_issValid && o_issReady && !w_issRdZero;
    end

    // Clear first, then set, so an issue and a write-back to the same
    // register leaves the reservation standing.
    always_comb begin
        w_busyNext = r_busy;
        if (i_we) begin
            w_busyNext[i_a3] = 1'b0;
        end
        if (w_issAccept) begin
            w_busyNext[i_issRd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busyNext;
        end
    end

    // With bypass a same-cycle write-back already reports the register free.
    always_comb begin
        o_busy1 = r_busy[i_a1] && !(L_BYPASS && i_we && (i_a3 == i_a1));
        o_busy2 = r_busy[i_a2] && !(L_BYPASS && i_we && (i_a3 == i_a2));
    end

endmodule : reg_bank_sb_score

// File: rtl/reg_bank_sb.sv
// ---------------------------------------------------------------------------
// reg_bank_sb
// Two-read / one-write register bank with a busy-bit scoreboard, optional
// hard-wired zero register, optional write-to-read bypass and a wrapping
// count of accepted writes.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    reg_bank_sb_if.slave: reads (a1/a2 -> rd1/rd2, busy1/busy2),
//          write-back (a3/wd/we), issue (iss_valid/iss_rd -> iss_ready),
//          wr_count
// ---------------------------------------------------------------------------
module reg_bank_sb
    import reg_bank_sb_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input logic          clk,
    input logic          rst_n,
    reg_bank_sb_if.slave bus
);

    localparam int                DEPTH     = 1 << ADDR_W;
    localparam bit                L_ZERO_EN = (ZERO_REG != 0);
    localparam bit                L_BYPASS  = (BYPASS != 0);
    localparam logic [ADDR_W-1:0] L_ZERO_A  = ADDR_W'(ZERO_REG_IDX);

    logic [DATA_W-1:0]     r_regFile [DEPTH];
    logic [WR_COUNT_W-1:0] r_wrCount;
    logic                  w_wrEn;

    // A write to the zero register is dropped entirely, including the count.
    assign w_wrEn = bus.we && !(L_ZERO_EN && (bus.a3 == L_ZERO_A));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regFile[i] <= '0;
            end
            r_wrCount <= '0;
        end else if (w_wrEn) begin
            r_regFile[bus.a3] <= bus.wd;
            r_wrCount         <= r_wrCount + WR_COUNT_W'(1);
        end
    end

    // Zero-register override is applied last so it beats any bypass.
    always_comb begin
        bus.rd1 = r_regFile[bus.a1];
        if (L_BYPASS && w_wrEn && (bus.a3 == bus.a1)) begin
            bus.rd1 = bus.wd;
        end
        if (L_ZERO_EN && (bus.a1 == L_ZERO_A)) begin
            bus.rd1 = '0;
        end
    end

    always_comb begin
        bus.rd2 = r_regFile[bus.a2];
        if (L_BYPASS && w_wrEn && (bus.a3 == bus.a2)) begin
            bus.rd2 = bus.wd;
        end
        if (L_ZERO_EN && (bus.a2 == L_ZERO_A)) begin
            bus.rd2 = '0;
        end
    end

    assign bus.wr_count = r_wrCount;

    reg_bank_sb_score #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_score (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_a1       (bus.a1),
        .i_a2       (bus.a2),
        .i_a3       (bus.a3),
        .i_we       (bus.we),
        .i_issValid (bus.iss_valid),
        .i_issRd    (bus.iss_rd),
        .o_busy1    (bus.busy1),
        .o_busy2    (bus.busy2),
        .o_issReady (bus.iss_ready)
    );

endmodule : reg_bank_sb

// File: tb/tb_reg_bank_sb.sv
// ---------------------------------------------------------------------------
// tb_reg_bank_sb
// Directed bench for reg_bank_sb with default parameters (32-bit data,
// 32 registers, zero register and bypass enabled). Inputs change on the
// falling clock edge and outputs are sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_reg_bank_sb;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    reg_bank_sb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) busIf ();

    reg_bank_sb #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (1),
        .BYPASS   (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busIf)
    );

    // 10 ns clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Return every driven input to an idle value.
    task automatic idle_inputs();
        busIf.a1        = '0;
        busIf.a2        = '0;
        busIf.a3        = '0;
        busIf.wd        = '0;
        busIf.we        = 1'b0;
        busIf.iss_valid = 1'b0;
        busIf.iss_rd    = '0;
    endtask

    // Reset state of the read ports, scoreboard and counter.
    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        busIf.a1     = 5'd5;
        busIf.a2     = 5'd31;
        busIf.iss_rd = 5'd4;
        #1;
        checks++; if (busIf.rd1 !== 32'h0) begin errors++; $display("[TB] FAIL reset_rd1: got %h expected %h", busIf.rd1, 32'h0); end
        checks++; if (busIf.rd2 !== 32'h0) begin errors++; $display("[TB] FAIL reset_rd2: got %h expected %h", busIf.rd2, 32'h0); end
        checks++; if (busIf.busy1 !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy1: got %b expected 0", busIf.busy1); end
        checks++; if (busIf.busy2 !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy2: got %b expected 0", busIf.busy2); end
        checks++; if (busIf.wr_count !== 16'h0) begin errors++; $display("[TB] FAIL reset_wr_count: got %h expected %h", busIf.wr_count, 16'h0); end
        checks++; if (busIf.iss_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_iss_ready: got %b expected 1", busIf.iss_ready); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Same-cycle bypass of a write to reg 7, then the stored value.
    task automatic test_bypass();
        @(negedge clk);
        busIf.we = 1'b1;
        busIf.a3 = 5'd7;
        busIf.wd = 32'hDEADBEEF;
        busIf.a1 = 5'd7;
        busIf.a2 = 5'd8;
        #1;
        checks++; if (busIf.rd1 !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL bypass_rd1: got %h expected %h", busIf.rd1, 32'hDEADBEEF); end
        checks++; if (busIf.rd2 !== 32'h0) begin errors++; $display("[TB] FAIL bypass_rd2_other: got %h expected %h", busIf.rd2, 32'h0); end
        checks++; if (busIf.wr_count !== 16'd0) begin errors++; $display("[TB] FAIL bypass_count_before: got %0d expected 0", busIf.wr_count); end
        @(negedge clk);
        busIf.we = 1'b0;
        #1;
        checks++; if (busIf.rd1 !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL stored_rd1: got %h expected %h", busIf.rd1, 32'hDEADBEEF); end
        checks++; if (busIf.wr_count !== 16'd1) begin errors++; $display("[TB] FAIL stored_count: got %0d expected 1", busIf.wr_count); end
    endtask

    // Writes and issues to register 0 are ignored.
    task automatic test_zero_reg();
        @(negedge clk);
        busIf.we        = 1'b1;
        busIf.a3        = 5'd0;
        busIf.wd        = 32'h12345678;
        busIf.a1        = 5'd0;
        busIf.a2        = 5'd0;
        busIf.iss_valid = 1'b1;
        busIf.iss_rd    = 5'd0;
        #1;
        checks++; if (busIf.rd1 !== 32'h0) begin errors++; $display("[TB] FAIL zero_rd1_bypass: got %h expected %h", busIf.rd1, 32'h0); end
        checks++; if (busIf.iss_ready !== 1'b1) begin errors++; $display("[TB] FAIL zero_iss_ready: got %b expected 1", busIf.iss_ready); end
        @(negedge clk);
        busIf.we        = 1'b0;
        busIf.iss_valid = 1'b0;
        #1;
        checks++; if (busIf.rd2 !== 32'h0) begin errors++; $display("[TB] FAIL zero_rd2_stored: got %h expected %h", busIf.rd2, 32'h0); end
        checks++; if (busIf.busy1 !== 1'b0) begin errors++; $display("[TB] FAIL zero_busy: got %b expected 0", busIf.busy1); end
        checks++; if (busIf.wr_count !== 16'd1) begin errors++; $display("[TB] FAIL zero_count: got %0d expected 1", busIf.wr_count); end
    endtask

    // Reserve reg 3, reissue blocked, write-back frees it for the reissue.
    task automatic test_issue();
        @(negedge clk);
        busIf.iss_valid = 1'b1;
        busIf.iss_rd    = 5'd3;
        busIf.a1        = 5'd3;
        #1;
        checks++; if (busIf.iss_ready !== 1'b1) begin errors++; $display("[TB] FAIL issue_first_ready: got %b expected 1", busIf.iss_ready); end
        checks++; if (busIf.busy1 !== 1'b0) begin errors++; $display("[TB] FAIL issue_busy_before: got %b expected 0", busIf.busy1); end
        @(negedge clk);
        #1;
        checks++; if (busIf.busy1 !== 1'b1) begin errors++; $display("[TB] FAIL issue_busy_set: got %b expected 1", busIf.busy1); end
        checks++; if (busIf.iss_ready !== 1'b0) begin errors++; $display("[TB] FAIL issue_reissue_blocked: got %b expected 0", busIf.iss_ready); end
        busIf.we = 1'b1;
        busIf.a3 = 5'd3;
        busIf.wd = 32'h00000011;
        #1;
        checks++; if (busIf.iss_ready !== 1'b1) begin errors++; $display("[TB] FAIL issue_wb_ready: got %b expected 1", busIf.iss_ready); end
        checks++; if (busIf.busy1 !== 1'b0) begin errors++; $display("[TB] FAIL issue_wb_busy_bypass: got %b expected 0", busIf.busy1); end
        checks++; if (busIf.rd1 !== 32'h00000011) begin errors++; $display("[TB] FAIL issue_wb_rd1: got %h expected %h", busIf.rd1, 32'h11); end
        @(negedge clk);
        busIf.we        = 1'b0;
        busIf.iss_valid = 1'b0;
        #1;
        checks++; if (busIf.busy1 !== 1'b1) begin errors++; $display("[TB] FAIL issue_reserve_wins: got %b expected 1", busIf.busy1); end
        checks++; if (busIf.rd1 !== 32'h00000011) begin errors++; $display("[TB] FAIL issue_data_written: got %h expected %h", busIf.rd1, 32'h11); end
        checks++; if (busIf.wr_count !== 16'd2) begin errors++; $display("[TB] FAIL issue_count: got %0d expected 2", busIf.wr_count); end
        busIf.we = 1'b1;
        busIf.a3 = 5'd3;
        busIf.wd = 32'h00000022;
        @(negedge clk);
        busIf.we = 1'b0;
        #1;
        checks++; if (busIf.busy1 !== 1'b0) begin errors++; $display("[TB] FAIL issue_wb_clears: got %b expected 0", busIf.busy1); end
        checks++; if (busIf.rd1 !== 32'h00000022) begin errors++; $display("[TB] FAIL issue_wb_data: got %h expected %h", busIf.rd1, 32'h22); end
    endtask

    // Write-back to a register that was never reserved.
    task automatic test_nonbusy_write();
        @(negedge clk);
        busIf.we = 1'b1;
        busIf.a3 = 5'd12;
        busIf.wd = 32'hCAFEF00D;
        busIf.a2 = 5'd12;
        @(negedge clk);
        busIf.we = 1'b0;
        #1;
        checks++; if (busIf.rd2 !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL nonbusy_rd2: got %h expected %h", busIf.rd2, 32'hCAFEF00D); end
        checks++; if (busIf.busy2 !== 1'b0) begin errors++; $display("[TB] FAIL nonbusy_busy2: got %b expected 0", busIf.busy2); end
        checks++; if (busIf.wr_count !== 16'd4) begin errors++; $display("[TB] FAIL nonbusy_count: got %0d expected 4", busIf.wr_count); end
    endtask

    // Asynchronous reset in the middle of a cycle with traffic in flight.
    task automatic test_reset_mid();
        @(negedge clk);
        busIf.we        = 1'b1;
        busIf.a3        = 5'd9;
        busIf.wd        = 32'hA5A5A5A5;
        busIf.iss_valid = 1'b1;
        busIf.iss_rd    = 5'd9;
        busIf.a1        = 5'd9;
        busIf.a2        = 5'd10;
        @(negedge clk);
        busIf.we        = 1'b0;
        busIf.iss_valid = 1'b0;
        #1;
        checks++; if (busIf.rd1 !== 32'hA5A5A5A5) begin errors++; $display("[TB] FAIL mid_pre_rd1: got %h expected %h", busIf.rd1, 32'hA5A5A5A5); end
        checks++; if (busIf.busy1 !== 1'b1) begin errors++; $display("[TB] FAIL mid_pre_busy1: got %b expected 1", busIf.busy1); end
        @(negedge clk);
        busIf.we        = 1'b1;
        busIf.a3        = 5'd9;
        busIf.wd        = 32'hFFFFFFFF;
        busIf.iss_valid = 1'b1;
        busIf.iss_rd    = 5'd10;
        #2;
        rst_n = 1'b0;
        #1;
        busIf.we        = 1'b0;
        busIf.iss_valid = 1'b0;
        #1;
        checks++; if (busIf.rd1 !== 32'h0) begin errors++; $display("[TB] FAIL mid_rd1_cleared: got %h expected %h", busIf.rd1, 32'h0); end
        checks++; if (busIf.busy1 !== 1'b0) begin errors++; $display("[TB] FAIL mid_busy1_cleared: got %b expected 0", busIf.busy1); end
        checks++; if (busIf.wr_count !== 16'd0) begin errors++; $display("[TB] FAIL mid_count_cleared: got %0d expected 0", busIf.wr_count); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (busIf.rd1 !== 32'h0) begin errors++; $display("[TB] FAIL mid_write_discarded: got %h expected %h", busIf.rd1, 32'h0); end
        checks++; if (busIf.busy2 !== 1'b0) begin errors++; $display("[TB] FAIL mid_issue_discarded: got %b expected 0", busIf.busy2); end
    endtask

    // 65536 consecutive writes to reg 1 wrap the counter back to zero.
    task automatic test_wrap();
        @(negedge clk);
        busIf.we = 1'b1;
        busIf.a3 = 5'd1;
        busIf.wd = 32'h00000001;
        busIf.a1 = 5'd1;
        repeat (65535) @(posedge clk);
        #1;
        checks++; if (busIf.wr_count !== 16'hFFFF) begin errors++; $display("[TB] FAIL wrap_max: got %h expected %h", busIf.wr_count, 16'hFFFF); end
        @(posedge clk);
        @(negedge clk);
        busIf.we = 1'b0;
        #1;
        checks++; if (busIf.wr_count !== 16'h0000) begin errors++; $display("[TB] FAIL wrap_zero: got %h expected %h", busIf.wr_count, 16'h0000); end
        checks++; if (busIf.rd1 !== 32'h00000001) begin errors++; $display("[TB] FAIL wrap_rd1: got %h expected %h", busIf.rd1, 32'h1); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        idle_inputs();
        test_reset();
        test_bypass();
        test_zero_reg();
        test_issue();
        test_nonbusy_write();
        test_reset_mid();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_reg_bank_sb

// File: doc/reg_bank_sb.md
REG_BANK_SB -- requirements
Module: reg_bank_sb

Interface
REQ-001 Parameter DATA_W, default 32, data width of every register and data port.
REQ-002 Parameter ADDR_W, default 5, register address width; depth = 2**ADDR_W.
REQ-003 Parameter ZERO_REG, default 1, when 1 register 0 reads as zero and ignores writes and issues.
REQ-004 Parameter BYPASS, default 1, when 1 a same-cycle write is forwarded to the read ports.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 a1, a2  in  ADDR_W  read addresses.
REQ-008 rd1, rd2  out  DATA_W  read data (combinational from a1/a2).
REQ-009 busy1, busy2  out  1  scoreboard busy bit of a1/a2 (combinational).
REQ-010 a3  in  ADDR_W  write-back address.
REQ-011 wd  in  DATA_W  write-back data.
REQ-012 we  in  1  write-back enable; also clears busy bit of a3.
REQ-013 iss_valid  in  1  issue request reserving destination iss_rd.
REQ-014 iss_rd  in  ADDR_W  destination register of the issue request.
REQ-015 iss_ready  out  1  issue accepted this cycle when iss_valid and iss_ready both high.
REQ-016 wr_count  out  16  number of accepted writes since reset (wrapping).

Function
REQ-017 Storage: 2**ADDR_W registers of DATA_W bits plus one busy bit per register.
REQ-018 Write: on rising edge with we=1, reg[a3] <= wd, except a3=0 when ZERO_REG=1 (ignored, not counted).
REQ-019 Read: rdN = reg[aN]; rdN = 0 when aN=0 and ZERO_REG=1.
REQ-020 Bypass: BYPASS=1, we=1, a3=aN, a3 writable -> rdN = wd in the same cycle; BYPASS=0 -> old value until next edge.
REQ-021 Busy read: busyN = busy[aN]; BYPASS=1 and we=1, a3=aN -> busyN = 0 in the same cycle.
REQ-022 iss_ready = !busy[iss_rd] OR (we=1 AND a3=iss_rd); always 1 for iss_rd=0 when ZERO_REG=1.
REQ-023 Accepted issue (iss_valid AND iss_ready) sets busy[iss_rd] at the next edge; iss_rd=0 with ZERO_REG=1 sets nothing.
REQ-024 Write-back with we=1 clears busy[a3] at the next edge.
REQ-025 Simultaneous accepted issue and write-back to the same register: busy stays set and data is written (new reservation wins).
REQ-026 Write-back to a non-busy register is legal: data written, busy stays 0.
REQ-027 wr_count increments by 1 per accepted write, wraps 0xFFFF -> 0x0000.
REQ-028 Latency: write visible on rd ports one cycle after edge (zero with bypass); busy update one cycle.

Reset
REQ-029 rst_n low asynchronously clears all registers to 0, all busy bits to 0, wr_count to 0.
REQ-030 rst_n low mid-operation discards any in-flight write or issue in that cycle; outputs reflect cleared state immediately.
REQ-031 First state update after rst_n deassertion occurs on the first rising clk edge with rst_n high.

Structure
REQ-032 Shared package holds DATA_W/ADDR_W defaults and the zero-register index constant.
REQ-033 Sub-module reg_bank_sb_score (busy-bit array, iss_ready, busy1/busy2) is instantiated once; data array stays in the top.

Verification
REQ-034 Reset then read a1=5, a2=31 -> rd1=0, rd2=0, busy1=busy2=0, wr_count=0.
REQ-035 we=1, a3=7, wd=0xDEADBEEF, a1=7, BYPASS=1 -> rd1=0xDEADBEEF same cycle; next cycle still 0xDEADBEEF, wr_count=1.
REQ-036 we=1, a3=0, wd=0x12345678 (ZERO_REG=1) -> rd1 at a1=0 stays 0, wr_count unchanged.
REQ-037 Issue iss_rd=3 -> busy[3]=1, second issue to 3 sees iss_ready=0; we=1 a3=3 same cycle as reissue -> iss_ready=1, busy[3] stays 1.
REQ-038 Write 0xA5A5A5A5 to reg 9, busy[9]=1, pulse rst_n low mid-cycle -> rd at 9 = 0 and busy[9]=0 without clock edge.
REQ-039 65536 writes to reg 1 -> wr_count wraps to 0x0000.
